// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        FAULT    = 2'd3
    } ctrl_state_t;

    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic pc_write;
        logic pc_src_branch;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_HALT = '0;

    localparam stage_ctrl_t CTRL_RESET = '{
        pc_write: 1'b0, pc_src_branch: 1'b0,
        if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0, mem_wb_write: 1'b0,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_flush: 1'b1
    };

    localparam stage_ctrl_t CTRL_INIT = '{
        pc_write: 1'b0, pc_src_branch: 1'b0,
        if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1, mem_wb_write: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_flush: 1'b1
    };

    localparam stage_ctrl_t CTRL_ADVANCE = '{
        pc_write: 1'b1, pc_src_branch: 1'b0,
        if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1, mem_wb_write: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b0
    };

    // Whole pipe frozen while a bubble drains into WB.
    localparam stage_ctrl_t CTRL_MEM_STALL = '{
        pc_write: 1'b0, pc_src_branch: 1'b0,
        if_id_write: 1'b0, id_ex_write: 1'b0, ex_mem_write: 1'b0, mem_wb_write: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b1
    };

    // Branch beats load-use: the ID instruction is on the wrong path anyway.
    function automatic stage_ctrl_t ctrl_run(input logic branch, input logic hazard);
        stage_ctrl_t c;
        c = CTRL_ADVANCE;
        if (branch) begin
            c.pc_src_branch = 1'b1;
            c.if_id_flush   = 1'b1;
            c.id_ex_flush   = 1'b1;
        end else if (hazard) begin
            c.pc_write    = 1'b0;
            c.if_id_write = 1'b0;
            c.id_ex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the ID operands and the EX load.
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  hazard
);

    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    assign rd_live = ex_mem_read && (ex_rd != REG_ADDR_W'(REG_ZERO));
    assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    assign hazard  = rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; Mealy outputs from a registered FSM.
// Optional perf counters are built when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mem_access,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  pc_src_branch,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  ex_mem_write,
    output logic                  mem_wb_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_flush,
    output logic                  fault,
    output logic [1:0]            state_o
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
`endif
);

    localparam int unsigned ICNT_W  = 4;
    localparam int unsigned TCNT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    ctrl_state_t       state_q, state_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    stage_ctrl_t       ctrl;
    logic              hazard;
    logic              mem_busy;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard      (hazard)
    );

    assign mem_busy = mem_access && !dmem_ready;

    // Next state and Mealy stage controls.
    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        tcnt_d  = tcnt_q;
        ctrl    = CTRL_HALT;
        unique case (state_q)
            INIT: begin
                ctrl   = CTRL_INIT;
                icnt_d = icnt_q + ICNT_W'(1);
                if (icnt_q == ICNT_W'(INIT_CYCLES - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (mem_busy) begin
                    ctrl    = CTRL_MEM_STALL;
                    state_d = MEM_WAIT;
                    tcnt_d  = '0;
                end else begin
                    ctrl = ctrl_run(ex_branch_taken, hazard);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    ctrl    = ctrl_run(ex_branch_taken, hazard);
                    state_d = RUN;
                end else begin
                    ctrl = CTRL_MEM_STALL;
                    if (MEM_TIMEOUT != 0) begin
                        if (tcnt_q == TCNT_W'(TO_LAST)) begin
                            state_d = FAULT;
                        end else begin
                            tcnt_d = tcnt_q + TCNT_W'(1);
                        end
                    end
                end
            end
            FAULT: begin
                ctrl = CTRL_HALT;
            end
            default: begin
                state_d = INIT;
            end
        endcase
        if (!rst) begin
            ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            icnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_src_branch = ctrl.pc_src_branch;
    assign if_id_write   = ctrl.if_id_write;
    assign id_ex_write   = ctrl.id_ex_write;
    assign ex_mem_write  = ctrl.ex_mem_write;
    assign mem_wb_write  = ctrl.mem_wb_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign mem_wb_flush  = ctrl.mem_wb_flush;
    assign fault         = (state_q == FAULT);
    assign state_o       = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic        stall_evt;
    logic        flush_evt;
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;

    // Stalls are RUN load-use bubbles plus every MEM_WAIT cycle; flushes are applied redirects.
    always_comb begin
        stall_evt = (state_q == MEM_WAIT)
                 || ((state_q == RUN) && !mem_busy && !ex_branch_taken && hazard);
        flush_evt = ex_branch_taken
                 && (((state_q == RUN) && !mem_busy) || ((state_q == MEM_WAIT) && dmem_ready));
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_evt && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
        if (flush_evt && (flush_q != '1)) begin
            flush_d = flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Drives the write-enable and flush inputs of the PC and of the IF_ID, ID_EX, EX_MEM and MEM_WB registers.
- Resolves load-use hazards, taken-branch redirects and multi-cycle data-memory waits, with a post-reset pipeline purge and a memory-timeout fault.
- Sits beside the hazard and forwarding units; those remain purely combinational.

Parameters:
- REG_ADDR_W, 5, register index width.
- INIT_CYCLES, 4, cycles of full flush after reset before fetch starts (1..15).
- MEM_TIMEOUT, 16, max MEM_WAIT cycles before fault; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_rs1  in  REG_ADDR_W  rs1 of the instruction in ID.
- id_rs2  in  REG_ADDR_W  rs2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_access  in  1  MEM-stage instruction is a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- pc_src_branch  out  1  PC takes the branch target.
- if_id_write, id_ex_write, ex_mem_write, mem_wb_write  out  1 each  stage register enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load a bubble on the next edge when the matching enable is 1.
- fault  out  1  sticky memory-timeout error.
- state_o  out  2  current FSM state encoding.

Behaviour:
- FSM states (registered): INIT=0, RUN=1, MEM_WAIT=2, FAULT=3.
- Outputs are Mealy: combinational from the current state plus the inputs.
- Reset (rst low, asynchronous):
  - state=INIT, init counter=0, timeout counter=0, fault=0.
  - While rst is low, all enables are 0, all flushes are 1 and pc_src_branch is 0.
- INIT:
  - All stage enables 1, all flushes 1, pc_write=0.
  - Init counter increments each cycle.
  - After INIT_CYCLES cycles go to RUN; the first fetch enable is in the first RUN cycle.
- RUN priority, highest first:
  1. Memory busy (mem_access=1 and dmem_ready=0):
     - All enables 0, except mem_wb_write=1 with mem_wb_flush=1 (bubble into WB).
     - pc_src_branch=0. Next state MEM_WAIT, timeout counter cleared.
  2. Branch (ex_branch_taken=1):
     - pc_write=1, pc_src_branch=1, if_id_flush=1, id_ex_flush=1, all enables 1.
     - Branch beats load-use, because the ID instruction is on the wrong path.
  3. Load-use:
     - Condition: ex_mem_read=1, ex_rd!=0, and (id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd).
     - pc_write=0, if_id_write=0, id_ex_flush=1. EX_MEM and MEM_WB advance.
     - Exactly one bubble per hazard; the next cycle's compare sees the load in MEM.
  4. Otherwise: all enables 1, no flush.
  - mem_access=1 with dmem_ready=1 in the same cycle causes no stall.
- MEM_WAIT:
  - Outputs are the same as RUN case 1. Timeout counter increments each cycle.
  - When dmem_ready=1: release. All enables 1, and the branch/load-use rules apply as in RUN. Next state RUN.
  - A taken branch held in EX redirects only on the release cycle, so pc_src_branch=1 is never asserted while pc_write=0.
  - MEM_TIMEOUT!=0 and counter reaches MEM_TIMEOUT without ready: go to FAULT.
  - If ready arrives on the same cycle the counter hits the limit, ready wins.
- FAULT: all enables 0, flushes 0, fault=1. Sticky until rst.
- Register index 0 never creates a hazard.
- A reset asserted mid-stall aborts the stall immediately; no state is retained.

Optional Feature:
- Macro: PIPELINE_CTRL_PERF_EN.
- Enabled: adds 32-bit saturating output counters:
  - stall_cycles: counts RUN load-use cycles plus MEM_WAIT cycles.
  - flush_count: counts taken-branch flushes.
  - Both clear on reset.
- Disabled: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package pipeline_ctrl_pkg:
  - state enum ctrl_state_t {INIT, RUN, MEM_WAIT, FAULT}, 2 bits.
  - constant REG_ZERO=0.
  - struct stage_ctrl_t grouping the enable and flush bits.
- One natural sub-module: load_use_detect, purely combinational.
  - Inputs: id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd.
  - Output: hazard.

Test Plan:
- Reset release with INIT_CYCLES=4 -> flushes high for 4 cycles, pc_write=0. First pc_write=1 in cycle 5, state_o=1.
- Load x5 in EX, ID "add x6,x5,x1" (uses rs1) -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_flush=1. With ex_rd=0, or id_uses_rs1=0, -> no stall.
- Taken branch plus a simultaneous load-use -> pc_src_branch=1, if_id_flush=1, id_ex_flush=1, pc_write=1. No stall cycle.
- mem_access=1, dmem_ready low for 3 cycles -> 3 cycles of enables 0 with mem_wb_flush=1, then release on cycle 4, state back to RUN. A held taken branch asserts pc_src_branch only on the release cycle.
- MEM_TIMEOUT=16, dmem_ready never asserted -> FAULT after 16 wait cycles, fault=1, all enables 0. Stays there until rst pulses low, then state_o=0.
- With PIPELINE_CTRL_PERF_EN: two load-use stalls plus a 3-cycle memory wait -> stall_cycles=5. One taken branch -> flush_count=1.
